// File: rtl/risk_pkg.sv
// Shared constants for the register-file controller and its arbiter.
package risk_pkg;

    localparam int XLEN = 32;   // data width
    localparam int NREG = 32;   // architectural registers, x0 hardwired zero
    localparam int SELW = 5;    // register select width, log2(NREG)

    // Round-robin pointer encoding: which side wins the next contested cycle.
    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. req[0]/gnt[0] is side A, req[1]/gnt[1] is side B.
// A lone requester always wins; the pointer only moves after a contested grant,
// and then moves to the side that lost.
module rr_arb2
    import risk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q;

    // Grant: uncontested requests pass straight through, contested ones follow the pointer.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (ptr_q == GNT_A) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Pointer: hand priority to the other side after every contested grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= GNT_A;
        end else if (req == 2'b11) begin
            ptr_q <= (ptr_q == GNT_A) ? GNT_B : GNT_A;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file controller: arbitrates the single write port between the ALU (A)
// and load unit (B) writebacks, and holds decode reads off registers that have
// an outstanding claimed writeback (busy scoreboard).
//
// Handshakes: every *_ready is a same-cycle combinational answer to its *_valid.
// A transfer happens in a cycle where valid and ready are both 1; ready is never
// 1 without valid. Requesters hold their request until they see ready.
module regfile_ctrl
    import risk_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [SELW-1:0] a_sel,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [SELW-1:0] b_sel,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            claim_valid,
    input  logic [SELW-1:0] claim_sel,
    output logic            claim_ready,
    input  logic            rq_valid,
    input  logic [SELW-1:0] rq_sel1,
    input  logic [SELW-1:0] rq_sel2,
    output logic            rq_ready,
    output logic            rsp_valid,
    output logic            rf_wr,
    output logic [SELW-1:0] rf_selwr,
    output logic [XLEN-1:0] rf_in,
    output logic            rf_rd,
    output logic [SELW-1:0] rf_selrd1,
    output logic [SELW-1:0] rf_selrd2
);

    // Bit 0 is kept at 0 so x0 never blocks anything.
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;
    logic [1:0]      gnt;
    logic            wr_hit;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({b_valid, a_valid}),
        .gnt (gnt)
    );

    // Write port: route the winner, drop writes to x0, default to A's inputs.
    always_comb begin
        a_ready  = gnt[0];
        b_ready  = gnt[1];
        rf_selwr = a_sel;
        rf_in    = a_data;
        if (gnt[1]) begin
            rf_selwr = b_sel;
            rf_in    = b_data;
        end
        rf_wr = (gnt[0] || gnt[1]) && (rf_selwr != '0);
    end

    // Read gating: no bypass, so a read colliding with this cycle's write waits a cycle.
    always_comb begin
        wr_hit      = rf_wr && ((rf_selwr == rq_sel1) || (rf_selwr == rq_sel2));
        rq_ready    = rq_valid && !busy_q[rq_sel1] && !busy_q[rq_sel2] && !wr_hit;
        rf_rd       = rq_ready;
        rf_selrd1   = rq_sel1;
        rf_selrd2   = rq_sel2;
        claim_ready = claim_valid && !busy_q[claim_sel];
    end

    // Scoreboard update: writeback clears first, an accepted claim then sets, so a
    // claim landing with a write to the same free register leaves it busy.
    always_comb begin
        busy_nxt = busy_q;
        if (rf_wr) begin
            busy_nxt[rf_selwr] = 1'b0;
        end
        if (claim_ready) begin
            busy_nxt[claim_sel] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // Read response valid, aligned with the register file's registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= rq_ready;
        end
    end

endmodule
